// File: rtl/clk_div_multi.sv
// NCH independent integer clock dividers with per-channel enable, boundary-aligned
// ratio changes, global phase restart and per-period tick strobes.
module clk_div_multi #(
    parameter int unsigned NCH      = 2,
    parameter int unsigned DIV_W    = 8,
    parameter int unsigned INIT_DIV = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       div_en,
    input  logic [NCH*DIV_W-1:0] div_val,
    input  logic [NCH-1:0]       div_load,
    input  logic                 sync_start,
    output logic [NCH-1:0]       clk_out,
    output logic [NCH-1:0]       tick,
    output logic [NCH-1:0]       active,
    output logic [NCH-1:0]       load_pend
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t           state, state_nxt;
        logic [DIV_W-1:0] cnt, cnt_nxt;
        logic [DIV_W-1:0] ratio, ratio_nxt;
        logic [DIV_W-1:0] pending, pending_nxt;
        logic             clk_q, clk_nxt;
        logic             tick_q, tick_nxt;
        logic             pend_q, pend_nxt;
        logic [DIV_W-1:0] req;
        logic [DIV_W-1:0] n_eff;
        logic [DIV_W-1:0] h_eff;
        logic             boundary;
        logic             stop_now;

        // Effective ratio (ratios below 2 behave as 2) and high-phase length ceil(N/2)
        always_comb begin
            req      = div_val[i*DIV_W +: DIV_W];
            n_eff    = (ratio < DIV_W'(2)) ? DIV_W'(2) : ratio;
            h_eff    = n_eff - (n_eff >> 1);
            boundary = (state == ST_RUN) && (cnt == n_eff - DIV_W'(1));
            stop_now = boundary && !div_en[i];
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state   <= ST_IDLE;
                cnt     <= '0;
                ratio   <= DIV_W'(INIT_DIV);
                pending <= DIV_W'(INIT_DIV);
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
                pend_q  <= 1'b0;
            end else begin
                state   <= state_nxt;
                cnt     <= cnt_nxt;
                ratio   <= ratio_nxt;
                pending <= pending_nxt;
                clk_q   <= clk_nxt;
                tick_q  <= tick_nxt;
                pend_q  <= pend_nxt;
            end
        end

        always_comb begin
            state_nxt   = state;
            cnt_nxt     = cnt;
            ratio_nxt   = ratio;
            pending_nxt = pending;
            clk_nxt     = 1'b0;
            tick_nxt    = 1'b0;
            pend_nxt    = pend_q;

            // A pending ratio applied this cycle is consumed unless a fresh load replaces it
            if (div_load[i]) begin
                pending_nxt = req;
                pend_nxt    = 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    cnt_nxt = '0;
                    if (pend_q) begin
                        ratio_nxt = pending;
                        if (!div_load[i]) pend_nxt = 1'b0;
                    end
                    if (div_en[i]) state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (sync_start && !stop_now) begin
                        cnt_nxt  = '0;
                        pend_nxt = 1'b0;
                        if (div_load[i]) ratio_nxt = req;
                        else if (pend_q) ratio_nxt = pending;
                    end else begin
                        clk_nxt  = (cnt < h_eff);
                        tick_nxt = (cnt == '0);
                        if (boundary) begin
                            cnt_nxt = '0;
                            if (pend_q) begin
                                ratio_nxt = pending;
                                if (!div_load[i]) pend_nxt = 1'b0;
                            end
                            if (stop_now) begin
                                state_nxt = ST_IDLE;
                                clk_nxt   = 1'b0;
                                tick_nxt  = 1'b0;
                            end
                        end else begin
                            cnt_nxt = cnt + DIV_W'(1);
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        assign clk_out[i]   = clk_q;
        assign tick[i]      = tick_q;
        assign active[i]    = (state == ST_RUN);
        assign load_pend[i] = pend_q;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Randomized bench for clk_div_multi against a timestamp-based period model.
module tb_clk_div_multi;

    localparam int unsigned NCH      = 2;
    localparam int unsigned DIV_W    = 8;
    localparam int unsigned INIT_DIV = 4;

    logic                 clk;
    logic                 reset;
    logic [NCH-1:0]       div_en;
    logic [NCH*DIV_W-1:0] div_val;
    logic [NCH-1:0]       div_load;
    logic                 sync_start;
    logic [NCH-1:0]       clk_out;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       active;
    logic [NCH-1:0]       load_pend;

    clk_div_multi #(
        .NCH      (NCH),
        .DIV_W    (DIV_W),
        .INIT_DIV (INIT_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .div_en     (div_en),
        .div_val    (div_val),
        .div_load   (div_load),
        .sync_start (sync_start),
        .clk_out    (clk_out),
        .tick       (tick),
        .active     (active),
        .load_pend  (load_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Model: each running channel remembers the cycle its current period began (t0);
    // position in the period is simply elapsed cycles since then.
    int cyc;
    int run  [NCH];
    int t0   [NCH];
    int n    [NCH];
    int pend [NCH];
    int pval [NCH];
    logic [NCH-1:0] e_clk, e_tick;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            run[c]  = 0;
            t0[c]   = 0;
            n[c]    = int'(INIT_DIV);
            pval[c] = int'(INIT_DIV);
            pend[c] = 0;
        end
        e_clk  = '0;
        e_tick = '0;
    endtask

    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            int pos, np, val;
            bit ld, en, bnd;
            pos = cyc - t0[c];
            np  = (n[c] < 2) ? 2 : n[c];
            val = int'(div_val[c*DIV_W +: DIV_W]);
            ld  = div_load[c];
            en  = div_en[c];
            bnd = (run[c] != 0) && (pos == np - 1);
            e_clk[c]  = 1'b0;
            e_tick[c] = 1'b0;
            if (run[c] == 0) begin
                if (pend[c] != 0) begin n[c] = pval[c]; pend[c] = 0; end
                if (ld) begin pval[c] = val; pend[c] = 1; end
                if (en) begin run[c] = 1; t0[c] = cyc + 1; end
            end else if (sync_start && !(bnd && !en)) begin
                t0[c] = cyc + 1;
                if (ld) begin n[c] = val; pval[c] = val; end
                else if (pend[c] != 0) n[c] = pval[c];
                pend[c] = 0;
            end else begin
                e_clk[c]  = (pos < (np + 1) / 2);
                e_tick[c] = (pos == 0);
                if (bnd) begin
                    t0[c] = cyc + 1;
                    if (pend[c] != 0) begin n[c] = pval[c]; pend[c] = 0; end
                    if (!en) run[c] = 0;
                end
                if (ld) begin pval[c] = val; pend[c] = 1; end
            end
        end
        cyc++;
    endtask

    function automatic logic [NCH-1:0] exp_active();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = (run[c] != 0);
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_pend();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = (pend[c] != 0);
        return v;
    endfunction

    // Called at a negedge with inputs already driven; returns at the next negedge
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("clk_out", 32'(clk_out), 32'(e_clk));
        check("tick", 32'(tick), 32'(e_tick));
        check("active", 32'(active), 32'(exp_active()));
        check("load_pend", 32'(load_pend), 32'(exp_pend()));
        @(negedge clk);
        div_load   = '0;
        sync_start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_clk_out"}, 32'(clk_out), 32'd0);
        check({tag, "_tick"}, 32'(tick), 32'd0);
        check({tag, "_active"}, 32'(active), 32'd0);
        check({tag, "_load_pend"}, 32'(load_pend), 32'd0);
    endtask

    task automatic random_cycles(input int count);
        for (int k = 0; k < count; k++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 39) == 0) div_en[c] = ~div_en[c];
                if ($urandom_range(0, 9) == 0) begin
                    div_load[c] = 1'b1;
                    div_val[c*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 9));
                end
            end
            sync_start = ($urandom_range(0, 29) == 0);
            step();
        end
    endtask

    logic pat_clk [8];
    logic pat_tick[8];

    initial begin
        pat_clk  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        pat_tick = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        reset      = 1'b1;
        div_en     = '0;
        div_val    = '0;
        div_load   = '0;
        sync_start = 1'b0;
        cyc        = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Both channels at the reset ratio: first edge two cycles after enable
        div_en = '1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("first_edges_clk0", 32'(clk_out[0]), 32'(pat_clk[k]));
            check("first_edges_tick1", 32'(tick[1]), 32'(pat_tick[k]));
        end

        random_cycles(3000);

        // Async reset in the middle of a high phase
        div_en = '1;
        begin
            int guard;
            guard = 0;
            while (!(e_clk[0] && run[0] != 0) && guard < 40) begin
                step();
                guard++;
            end
            if (guard >= 40) check("reach_high_phase", 32'd0, 32'd1);
        end
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            check("recover_clk0", 32'(clk_out[0]), 32'(pat_clk[k]));
        end

        random_cycles(3000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised successor to the fixed two-output clock divider: NCH independent divided-clock channels from one `clk`, each with a runtime-programmable integer ratio.
- Adds per-channel enable, glitch-free ratio change at period boundaries, global phase-align (`sync_start`) and per-period tick strobes.
- Feeds the FIFO write/read clock domains and any future slow-clock consumers.
- All outputs are registered, posedge `clk` only; no negedge logic, no gated clocks.

Parameters:
- NCH, 2, number of divider channels (1..8)
- DIV_W, 8, width of the per-channel divide ratio
- INIT_DIV, 4, ratio loaded into every channel at reset (2..2^DIV_W-1)

Ports:
- clk  in  1  source clock
- reset  in  1  asynchronous, active-high reset
- div_en  in  NCH  per-channel enable, level
- div_val  in  NCH*DIV_W  requested ratio; channel i uses bits [i*DIV_W +: DIV_W]
- div_load  in  NCH  one-cycle strobe; captures div_val[i] into the pending register
- sync_start  in  1  one-cycle strobe; restarts all enabled channels in phase
- clk_out  out  NCH  divided clock, registered
- tick  out  NCH  one-cycle pulse, coincident with each clk_out rising edge
- active  out  NCH  channel currently running, registered
- load_pend  out  NCH  a captured ratio is waiting for the next boundary

Behaviour:
- Reset (async, while reset=1):
  - cnt=0, ratio=pending=INIT_DIV.
  - clk_out=0, tick=0, active=0, load_pend=0.
- Ratio clamp: N = max(ratio, 2); a div_val of 0 or 1 is treated as 2.
- High phase: H = ceil(N/2) cycles; low phase = N-H cycles.
- Period boundary: cnt==N-1 while running.
- Running channel, each clk cycle:
  - cnt advances 0..N-1, then wraps to 0.
  - clk_out <= (cnt < H), registered from the current cnt, so clk_out lags cnt by one cycle.
  - tick <= (cnt==0).
- Start:
  - If div_en[i]=1 and active[i]=0, then next cycle active=1 and cnt=0.
  - clk_out rises and tick pulses one cycle after that.
  - First edge appears 2 clk cycles after div_en rises.
- Stop (glitch-free):
  - div_en falling is honoured only at the period boundary.
  - At the boundary: active=0, cnt=0, clk_out=0, no further ticks.
  - Re-asserting div_en before the boundary cancels the stop; the period is not shortened.
- Ratio change:
  - div_load[i] copies div_val[i] to pending[i] and sets load_pend[i].
  - A second load before the boundary overwrites pending; only the last value applies.
  - Channel running: ratio<=pending at the period boundary, load_pend clears there, and the new N governs the next period. No period is ever truncated.
  - Channel inactive: ratio<=pending on the cycle after div_load; load_pend is high for exactly one cycle.
- sync_start:
  - Every active channel: cnt<=0, clk_out<=0, and pending ratios apply immediately (load_pend clears).
  - Following cycle: cnt=0 is evaluated, so all active channels rise and tick on the same cycle.
  - Inactive channels ignore it.
  - If sync_start and div_load[i] coincide, the new div_val[i] is applied directly.
- Simultaneous events:
  - Boundary and div_load on the same cycle: the old pending value applies at the boundary, and the new value becomes pending for the following boundary.
  - Boundary and div_en falling on the same cycle: the channel stops at that boundary.
- Reset mid-operation: all outputs drop in the same instant as reset asserts. Recovery starts at cnt=0 on the first clk after deassert.
- Channels are fully independent, apart from the shared sync_start.

Test Plan:
- Reset, then div_en=2'b11 with INIT_DIV=4 -> both clk_out have period 4 (2 high / 2 low); first rising edge 2 cycles after enable; tick asserted only on rising-edge cycles.
- Ch0: div_val=5, load, run 20 cycles -> 3 high / 2 low. Ch1: div_val=1 -> behaves as N=2 (1 high / 1 low).
- Ch0 running at N=6, load 3 at cnt=2 -> current period completes its full 6 cycles; the next periods are 3 cycles; load_pend high from the load until the boundary.
- Ch0 at N=8, drop div_en at cnt=1 -> clk_out stays correct until cnt=7; active=0 and clk_out=0 after the boundary; no tick afterwards.
- Ch0 N=4, ch1 N=6, arbitrary offset, pulse sync_start -> tick[0] and tick[1] coincide on the cycle after the following one; they coincide again every 12 cycles.
- Assert reset asynchronously mid-high-phase -> clk_out, tick and active go 0 immediately. After release with div_en held, the first edge comes after 2 cycles at INIT_DIV.
